vend_ctrl_param: RTL and testbench

Parametrised successor to the team's 15-unit two-coin vending FSM. It accumulates coin credit against a configurable price and pulses a vend strobe when the price is met. Change and cancel refunds are returned serially, one coin per handshake, and a stock counter holds sold-out state with a restock pulse. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_stock_ctr.sv | 43 ++++
 rtl/vend_ctrl_param.sv | 139 +++++++++++++
 tb/tb_vend_ctrl_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller: coin codes,
// FSM state encoding and coin-value decoding.
package vend_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_A      = 2'b01;
    localparam logic [1:0] COIN_B      = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        RETURN  = 2'd3
    } state_t;

    // Cancel and "no coin" carry no value.
    function automatic int unsigned coin_value(
        input logic [1:0]  code,
        input int unsigned unit_a,
        input int unsigned unit_b
    );
        case (code)
            COIN_A:  coin_value = unit_a;
            COIN_B:  coin_value = unit_b;
            default: coin_value = 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_ctr.sv
// Stock down-counter: restock has priority over a sale, and sold_out is
// registered from the count so it trails a stock change by one cycle.
module vend_stock_ctr
    import vend_pkg::*;
#(
    parameter int STOCK_MAX = 3,
    parameter int STOCK_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic restock,
    output logic sold_out
);

    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);

    logic [STOCK_W-1:0] stock_reg;
    logic [STOCK_W-1:0] stock_next;
    logic               sold_out_reg;

    always_comb begin
        stock_next = stock_reg;
        if (restock) begin
            stock_next = STOCK_FULL;
        end else if (dec && (stock_reg != '0)) begin
            stock_next = stock_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stock_reg    <= STOCK_FULL;
            sold_out_reg <= 1'b0;
        end else begin
            stock_reg    <= stock_next;
            sold_out_reg <= (stock_reg == '0);
        end
    end

    assign sold_out = sold_out_reg;

endmodule

// File: rtl/vend_ctrl_param.sv
// Coin-credit vending controller: accumulates credit against PRICE, strobes
// vend, and pays change or cancel refunds back one UNIT_A coin per handshake.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int UNIT_A    = 5,
    parameter int UNIT_B    = 10,
    parameter int PRICE     = 15,
    parameter int CREDIT_W  = 8,
    parameter int STOCK_MAX = 3,
    parameter int STOCK_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                restock,
    input  logic                chg_ready,
    output logic                coin_ready,
    output logic                coin_rej,
    output logic                vend,
    output logic                chg_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out
);

    generate
        if ((UNIT_A <= 0) || (UNIT_B % UNIT_A != 0)) begin : g_bad_unit_b
            $error("vend_ctrl_param: UNIT_B must be a positive multiple of UNIT_A");
        end
        if ((PRICE % UNIT_A != 0) || (PRICE < UNIT_B)) begin : g_bad_price
            $error("vend_ctrl_param: PRICE must be a multiple of UNIT_A and >= UNIT_B");
        end
        if (PRICE - UNIT_A + UNIT_B >= 2 ** CREDIT_W) begin : g_bad_credit_w
            $error("vend_ctrl_param: CREDIT_W too narrow for PRICE-UNIT_A+UNIT_B");
        end
        if ((STOCK_MAX < 1) || (STOCK_MAX >= 2 ** STOCK_W)) begin : g_bad_stock
            $error("vend_ctrl_param: STOCK_MAX must be >= 1 and fit in STOCK_W");
        end
    endgenerate

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_X  = CREDIT_W'(UNIT_A);

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                vend_reg, vend_next;
    logic                coin_rej_reg, coin_rej_next;
    logic                stock_dec;
    logic                is_coin;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                chg_take;

    assign is_coin    = (in == COIN_A) || (in == COIN_B);
    assign coin_val   = (CREDIT_W+1)'(coin_value(in, UNIT_A, UNIT_B));
    assign credit_sum = {1'b0, credit_reg} + coin_val;

    assign coin_ready = ((state_reg == IDLE) || (state_reg == COLLECT)) && !sold_out;
    assign chg_valid  = (state_reg == RETURN) && (credit_reg != '0);
    assign chg_take   = chg_valid && chg_ready;

    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        vend_next     = 1'b0;
        coin_rej_next = 1'b0;
        stock_dec     = 1'b0;
        case (state_reg)
            IDLE, COLLECT: begin
                if (is_coin && coin_ready) begin
                    if (credit_sum >= PRICE_X) begin
                        // Remainder after the price is the change to pay out.
                        state_next  = VEND;
                        credit_next = CREDIT_W'(credit_sum - PRICE_X);
                        vend_next   = 1'b1;
                        stock_dec   = 1'b1;
                    end else begin
                        state_next  = COLLECT;
                        credit_next = CREDIT_W'(credit_sum);
                    end
                end else if (is_coin) begin
                    coin_rej_next = 1'b1;
                end else if ((in == COIN_CANCEL) && (state_reg == COLLECT)) begin
                    state_next = RETURN;
                end
            end
            VEND: begin
                coin_rej_next = is_coin;
                state_next    = (credit_reg != '0) ? RETURN : IDLE;
            end
            RETURN: begin
                coin_rej_next = is_coin;
                if (chg_take) begin
                    credit_next = credit_reg - UNIT_X;
                    if (credit_reg == UNIT_X) begin
                        state_next = IDLE;
                    end
                end else if (credit_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    // Reset drops any pending credit; the customer loses it by design.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            credit_reg   <= '0;
            vend_reg     <= 1'b0;
            coin_rej_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            credit_reg   <= credit_next;
            vend_reg     <= vend_next;
            coin_rej_reg <= coin_rej_next;
        end
    end

    vend_stock_ctr #(
        .STOCK_MAX (STOCK_MAX),
        .STOCK_W   (STOCK_W)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .dec      (stock_dec),
        .restock  (restock),
        .sold_out (sold_out)
    );

    assign vend     = vend_reg;
    assign coin_rej = coin_rej_reg;
    assign credit   = credit_reg;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param with default parameters (5/10 coins,
// price 15, stock 3); every step is followed by hand-computed checks.
module tb_vend_ctrl_param;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       restock;
    logic       chg_ready;
    logic       coin_ready;
    logic       coin_rej;
    logic       vend;
    logic       chg_valid;
    logic [7:0] credit;
    logic       sold_out;

    int n_checks = 0;
    int n_err    = 0;

    vend_ctrl_param dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .restock    (restock),
        .chg_ready  (chg_ready),
        .coin_ready (coin_ready),
        .coin_rej   (coin_rej),
        .vend       (vend),
        .chg_valid  (chg_valid),
        .credit     (credit),
        .sold_out   (sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge.
    task automatic step(input logic [1:0] c, input logic rs);
        in      = c;
        restock = rs;
        @(posedge clk);
        #1;
        in      = 2'b00;
        restock = 1'b0;
        $display("t=%0t in=%b rs=%b rdy=%b -> credit=%0d vend=%b chg_valid=%b rej=%b coin_ready=%b sold_out=%b",
                 $time, c, rs, chg_ready, credit, vend, chg_valid, coin_rej, coin_ready, sold_out);
    endtask

    // Sale of 5 then 10: vend on the second coin, no change.
    task automatic sale(input string tag);
        step(2'b01, 1'b0);
        chk({tag, "_c1_credit"}, 32'(credit), 5);
        step(2'b10, 1'b0);
        chk({tag, "_vend"}, 32'(vend), 1);
        chk({tag, "_credit"}, 32'(credit), 0);
        step(2'b00, 1'b0);
        chk({tag, "_vend_off"}, 32'(vend), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in        = 2'b00;
        restock   = 1'b0;
        chg_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_credit", 32'(credit), 0);
        chk("rst_vend", 32'(vend), 0);
        chk("rst_chg_valid", 32'(chg_valid), 0);
        chk("rst_sold_out", 32'(sold_out), 0);
        chk("rst_coin_rej", 32'(coin_rej), 0);
        rst = 1'b0;
        chk("rst_coin_ready", 32'(coin_ready), 1);

        // 1: three UNIT_A coins
        step(2'b01, 1'b0);
        chk("t1_credit5", 32'(credit), 5);
        chk("t1_vend0", 32'(vend), 0);
        step(2'b01, 1'b0);
        chk("t1_credit10", 32'(credit), 10);
        step(2'b01, 1'b0);
        chk("t1_vend", 32'(vend), 1);
        chk("t1_credit0", 32'(credit), 0);
        chk("t1_chg_valid", 32'(chg_valid), 0);
        chk("t1_busy", 32'(coin_ready), 0);
        step(2'b00, 1'b0);
        chk("t1_vend_off", 32'(vend), 0);
        chk("t1_chg_valid_idle", 32'(chg_valid), 0);
        chk("t1_idle_ready", 32'(coin_ready), 1);

        // 2: two UNIT_B coins, 5 change
        step(2'b10, 1'b0);
        chk("t2_credit10", 32'(credit), 10);
        step(2'b10, 1'b0);
        chk("t2_vend", 32'(vend), 1);
        chk("t2_change", 32'(credit), 5);
        step(2'b00, 1'b0);
        chk("t2_vend_off", 32'(vend), 0);
        chk("t2_chg_valid", 32'(chg_valid), 1);
        chk("t2_ret_credit", 32'(credit), 5);
        step(2'b00, 1'b0);
        chk("t2_credit0", 32'(credit), 0);
        chk("t2_chg_valid_off", 32'(chg_valid), 0);
        chk("t2_idle", 32'(coin_ready), 1);

        // 3: cancel with stalled hopper
        chg_ready = 1'b0;
        step(2'b10, 1'b0);
        chk("t3_credit10", 32'(credit), 10);
        step(2'b11, 1'b0);
        chk("t3_cancel_chg_valid", 32'(chg_valid), 1);
        chk("t3_cancel_credit", 32'(credit), 10);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0);
            chk("t3_stall_chg_valid", 32'(chg_valid), 1);
            chk("t3_stall_credit", 32'(credit), 10);
        end
        chg_ready = 1'b1;
        step(2'b00, 1'b0);
        chk("t3_hs1_credit", 32'(credit), 5);
        chk("t3_hs1_chg_valid", 32'(chg_valid), 1);
        chk("t3_vend0", 32'(vend), 0);
        step(2'b00, 1'b0);
        chk("t3_hs2_credit", 32'(credit), 0);
        chk("t3_hs2_chg_valid", 32'(chg_valid), 0);
        chk("t3_idle", 32'(coin_ready), 1);

        // 4: third sale empties stock (3 -> 0)
        sale("t4_sale3");
        chk("t4_sold_out", 32'(sold_out), 1);
        chk("t4_not_ready", 32'(coin_ready), 0);
        step(2'b01, 1'b0);
        chk("t4_rej", 32'(coin_rej), 1);
        chk("t4_rej_credit", 32'(credit), 0);
        step(2'b11, 1'b0);
        chk("t4_rej_off", 32'(coin_rej), 0);
        chk("t4_cancel_credit", 32'(credit), 0);
        step(2'b00, 1'b1);
        chk("t4_restock_lag", 32'(sold_out), 1);
        step(2'b00, 1'b0);
        chk("t4_restocked", 32'(sold_out), 0);
        chk("t4_ready", 32'(coin_ready), 1);
        sale("t4_sale_after");

        // 5: coins during VEND and RETURN are rejected (stock now 2)
        chg_ready = 1'b0;
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        chk("t5_vend", 32'(vend), 1);
        chk("t5_change", 32'(credit), 5);
        step(2'b01, 1'b0);
        chk("t5_rej_vend", 32'(coin_rej), 1);
        chk("t5_credit_vend", 32'(credit), 5);
        step(2'b01, 1'b0);
        chk("t5_rej_return", 32'(coin_rej), 1);
        chk("t5_credit_return", 32'(credit), 5);
        step(2'b00, 1'b0);
        chk("t5_rej_off", 32'(coin_rej), 0);
        chg_ready = 1'b1;
        step(2'b00, 1'b0);
        chk("t5_refund_done", 32'(credit), 0);
        // final unit sold with restock on the same edge
        step(2'b10, 1'b0);
        step(2'b01, 1'b1);
        chk("t5_final_vend", 32'(vend), 1);
        step(2'b00, 1'b0);
        chk("t5_restock_wins", 32'(sold_out), 0);
        sale("t5_s1");
        chk("t5_s1_stock", 32'(sold_out), 0);
        sale("t5_s2");
        chk("t5_s2_stock", 32'(sold_out), 0);
        sale("t5_s3");
        chk("t5_s3_sold_out", 32'(sold_out), 1);

        // 6: async reset mid-COLLECT
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);
        step(2'b10, 1'b0);
        chk("t6_credit10", 32'(credit), 10);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_credit", 32'(credit), 0);
        chk("t6_vend", 32'(vend), 0);
        chk("t6_chg_valid", 32'(chg_valid), 0);
        chk("t6_coin_rej", 32'(coin_rej), 0);
        chk("t6_sold_out", 32'(sold_out), 0);
        #1;
        rst = 1'b0;
        step(2'b01, 1'b0);
        chk("t6_fresh_credit", 32'(credit), 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
